// File: rtl/hsv_pkg.sv
// Shared widths and state type for the hsv_adjust configuration scheduler.
package hsv_pkg;

  localparam int CFG_W = 64;
  localparam int PIX_W = 10;
  localparam int H_W   = 25;
  localparam int SV_W  = 18;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOF,
    DRAIN,
    APPLY
  } hsv_sched_st_t;

endpackage

// File: rtl/hsv_vld_pipe.sv
// Valid/SOF delay line with the same depth as hsv_adjust, so the flags leave
// together with the pixel they describe; empty means no beat is in flight.
module hsv_vld_pipe #(
  parameter int LAT = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic in_valid,
  input  logic in_sof,
  output logic out_valid,
  output logic out_sof,
  output logic empty
);

  logic [LAT-1:0] vld_sr_q, vld_sr_d;
  logic [LAT-1:0] sof_sr_q, sof_sr_d;

  always_comb begin
    vld_sr_d    = vld_sr_q;
    sof_sr_d    = sof_sr_q;
    vld_sr_d[0] = in_valid;
    sof_sr_d[0] = in_valid & in_sof;
    for (int i = 1; i < LAT; i++) begin
      vld_sr_d[i] = vld_sr_q[i-1];
      sof_sr_d[i] = sof_sr_q[i-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_sr_q <= '0;
      sof_sr_q <= '0;
    end else begin
      vld_sr_q <= vld_sr_d;
      sof_sr_q <= sof_sr_d;
    end
  end

  assign out_valid = vld_sr_q[LAT-1];
  assign out_sof   = sof_sr_q[LAT-1];
  assign empty     = (vld_sr_q == '0);

endmodule

// File: rtl/hsv_cfg_sched.sv
// Applies host HSV words to hsv_adjust only at a safe point (next SOF, or at once
// with cfg_now) after stalling and draining the pixel pipe. HSV_CFG_CNT_EN adds cfg_count.
module hsv_cfg_sched
  import hsv_pkg::*;
#(
  parameter int LAT   = 8,
  parameter int CFG_W = hsv_pkg::CFG_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [CFG_W-1:0] cfg_data,
  input  logic             cfg_now,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             pix_valid,
  input  logic             pix_sof,
  output logic             pix_ready,
  output logic [CFG_W-1:0] HSV,
  output logic             out_valid,
  output logic             out_sof,
`ifdef HSV_CFG_CNT_EN
  output logic [7:0]       cfg_count,
`endif
  output logic             cfg_applied
);

  hsv_sched_st_t    state_q, state_d;
  logic [CFG_W-1:0] pend_q, pend_d;
  logic [CFG_W-1:0] hsv_q, hsv_d;
  logic             applied_q, applied_d;
  logic             pipe_empty;
  logic             pix_acc;

  assign pix_acc = pix_valid & pix_ready;

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    hsv_d     = hsv_q;
    applied_d = 1'b0;
    cfg_ready = 1'b0;
    pix_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        pix_ready = 1'b1;
        if (cfg_valid) begin
          pend_d  = cfg_data;
          state_d = cfg_now ? DRAIN : WAIT_SOF;
        end
      end
      WAIT_SOF: begin
        // The SOF beat is held back so the new frame starts on the new word.
        pix_ready = !(pix_valid && pix_sof);
        if (pix_valid && pix_sof) state_d = DRAIN;
      end
      DRAIN: begin
        if (pipe_empty) state_d = APPLY;
      end
      APPLY: begin
        hsv_d     = pend_q;
        applied_d = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      hsv_q     <= '0;
      applied_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      hsv_q     <= hsv_d;
      applied_q <= applied_d;
    end
  end

  hsv_vld_pipe #(.LAT(LAT)) u_vld_pipe (
    .CLK      (CLK),
    .RST      (RST),
    .in_valid (pix_acc),
    .in_sof   (pix_sof),
    .out_valid(out_valid),
    .out_sof  (out_sof),
    .empty    (pipe_empty)
  );

  assign HSV         = hsv_q;
  assign cfg_applied = applied_q;

`ifdef HSV_CFG_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb cnt_d = applied_q ? cnt_q + 8'd1 : cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cfg_count = cnt_q;
`endif

endmodule
